pipe_exe_md: RTL and testbench

- Parametrised successor of the decode/execute pipeline register plus execute stage.
- Merges the D/E register and the execute datapath into one block, parametrised in data width and link offset.
- Adds three behaviours: pipeline hold, bubble flush, and a multi-cycle iterative multiply/divide unit (MDU).
- While an MDU op is in progress, the block asserts e_busy so the hazard unit stalls IF/ID.

---
 rtl/pipe_exe_md.sv | 179 +++++++++++++++++
 tb/tb_pipe_exe_md.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_exe_md.sv
// Decode/execute pipeline register merged with the execute stage: ALU, jal link,
// hold/flush control and an iterative one-bit-per-cycle multiply/divide unit.
module pipe_exe_md #(
    parameter int W        = 32,
    parameter int RNW      = 5,
    parameter int SHW      = $clog2(W),
    parameter int LINK_OFS = 4
) (
    input  logic           clk,
    input  logic           clrn,
    input  logic           flush,
    input  logic           dwreg,
    input  logic           dm2reg,
    input  logic           dwmem,
    input  logic           daluimm,
    input  logic           dshift,
    input  logic           djal,
    input  logic [3:0]     daluc,
    input  logic [1:0]     dmd,
    input  logic [W-1:0]   da,
    input  logic [W-1:0]   db,
    input  logic [W-1:0]   dimm,
    input  logic [W-1:0]   dpc4,
    input  logic [RNW-1:0] drn,
    output logic           ewreg,
    output logic           em2reg,
    output logic           ewmem,
    output logic [W-1:0]   eb,
    output logic [RNW-1:0] ern,
    output logic [W-1:0]   ealu,
    output logic           e_busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_t;

    localparam logic [1:0] MD_MUL  = 2'b01;
    localparam logic [1:0] MD_REMU = 2'b11;

    logic           ealuimm, eshift, ejal;
    logic [3:0]     ealuc;
    logic [1:0]     emd;
    logic [W-1:0]   ea, eimm, epc4;
    logic [RNW-1:0] ern0;

    md_state_t      state;
    logic [SHW-1:0] cnt;
    logic [W-1:0]   md_a, md_b, md_acc;

    assign e_busy = (state == RUN) || (state == IDLE && emd != 2'b00);

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            ewreg   <= 1'b0;
            em2reg  <= 1'b0;
            ewmem   <= 1'b0;
            ealuimm <= 1'b0;
            eshift  <= 1'b0;
            ejal    <= 1'b0;
            ealuc   <= 4'd0;
            emd     <= 2'b00;
            ea      <= '0;
            eb      <= '0;
            eimm    <= '0;
            epc4    <= '0;
            ern0    <= '0;
        end else if (!e_busy) begin
            if (flush) begin
                ewreg   <= 1'b0;
                em2reg  <= 1'b0;
                ewmem   <= 1'b0;
                ealuimm <= 1'b0;
                eshift  <= 1'b0;
                ejal    <= 1'b0;
                ealuc   <= 4'd0;
                emd     <= 2'b00;
                ea      <= '0;
                eb      <= '0;
                eimm    <= '0;
                epc4    <= '0;
                ern0    <= '0;
            end else begin
                ewreg   <= dwreg;
                em2reg  <= dm2reg;
                ewmem   <= dwmem;
                ealuimm <= daluimm;
                eshift  <= dshift;
                ejal    <= djal;
                ealuc   <= daluc;
                emd     <= dmd;
                ea      <= da;
                eb      <= db;
                eimm    <= dimm;
                epc4    <= dpc4;
                ern0    <= drn;
            end
        end
    end

    logic [W-1:0]   alua, alub, alu0, md_res;
    logic [SHW-1:0] shamt;

    assign alua  = eshift ? W'(eimm[6+SHW-1:6]) : ea;
    assign alub  = ealuimm ? eimm : eb;
    assign shamt = alua[SHW-1:0];

    always_comb begin
        alu0 = '0;
        casez (ealuc)
            4'b?000: alu0 = alua + alub;
            4'b?100: alu0 = alua - alub;
            4'b?001: alu0 = alua & alub;
            4'b?101: alu0 = alua | alub;
            4'b?010: alu0 = alua ^ alub;
            4'b?110: alu0 = alub << (W/2);
            4'b?011: alu0 = alub << shamt;
            4'b0111: alu0 = alub >> shamt;
            4'b1111: alu0 = W'($signed(alub) >>> shamt);
            default: alu0 = '0;
        endcase
    end

    assign md_res = (emd == MD_MUL || emd == MD_REMU) ? md_acc : md_a;
    assign ealu   = (emd != 2'b00) ? md_res
                  : ejal ? epc4 + W'(LINK_OFS) : alu0;
    assign ern    = ejal ? '1 : ern0;

    // Restoring divide: md_acc is the partial remainder, md_a shifts the
    // dividend out at the top while quotient bits enter at the bottom.
    logic [W:0]   div_shift;
    logic         div_ge;
    logic [W-1:0] div_sub;

    assign div_shift = {md_acc, md_a[W-1]};
    assign div_ge    = div_shift >= {1'b0, md_b};
    assign div_sub   = div_shift[W-1:0] - md_b;

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state  <= IDLE;
            cnt    <= '0;
            md_a   <= '0;
            md_b   <= '0;
            md_acc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (emd != 2'b00) begin
                        md_a   <= ea;
                        md_b   <= eb;
                        md_acc <= '0;
                        cnt    <= SHW'(W-1);
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (emd == MD_MUL) begin
                        if (md_b[0])
                            md_acc <= md_acc + md_a;
                        md_a <= md_a << 1;
                        md_b <= md_b >> 1;
                    end else if (div_ge) begin
                        md_acc <= div_sub;
                        md_a   <= {md_a[W-2:0], 1'b1};
                    end else begin
                        md_acc <= div_shift[W-1:0];
                        md_a   <= {md_a[W-2:0], 1'b0};
                    end
                    if (cnt == '0)
                        state <= DONE;
                    else
                        cnt <= cnt - 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_exe_md.sv
// Bench for pipe_exe_md: random ALU/jal/MDU traffic against a plain-arithmetic
// reference, plus hold, flush and mid-operation reset scenarios.
module tb_pipe_exe_md;
    localparam int W        = 32;
    localparam int RNW      = 5;
    localparam int LINK_OFS = 4;

    logic           clk = 1'b0;
    logic           clrn;
    logic           flush;
    logic           dwreg, dm2reg, dwmem, daluimm, dshift, djal;
    logic [3:0]     daluc;
    logic [1:0]     dmd;
    logic [W-1:0]   da, db, dimm, dpc4;
    logic [RNW-1:0] drn;
    logic           ewreg, em2reg, ewmem, e_busy;
    logic [W-1:0]   eb, ealu;
    logic [RNW-1:0] ern;

    int errors = 0;
    int checks = 0;

    pipe_exe_md #(.W(W), .RNW(RNW), .LINK_OFS(LINK_OFS)) dut (
        .clk(clk), .clrn(clrn), .flush(flush),
        .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem),
        .daluimm(daluimm), .dshift(dshift), .djal(djal),
        .daluc(daluc), .dmd(dmd),
        .da(da), .db(db), .dimm(dimm), .dpc4(dpc4), .drn(drn),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .eb(eb), .ern(ern), .ealu(ealu), .e_busy(e_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop();
        flush = 0; dwreg = 0; dm2reg = 0; dwmem = 0; daluimm = 0; dshift = 0; djal = 0;
        daluc = 4'd0; dmd = 2'b00; da = '0; db = '0; dimm = '0; dpc4 = '0; drn = '0;
    endtask

    task automatic drive_random();
        flush = 1'($urandom); dwreg = 1'($urandom); dm2reg = 1'($urandom);
        dwmem = 1'($urandom); daluimm = 1'($urandom); dshift = 1'($urandom);
        djal = 1'($urandom); daluc = 4'($urandom); dmd = 2'($urandom);
        da = $urandom; db = $urandom; dimm = $urandom; dpc4 = $urandom; drn = 5'($urandom);
    endtask

    function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int sh;
        sh = int'(a % W);
        case (op[2:0])
            3'd0: return a + b;
            3'd4: return a - b;
            3'd1: return a & b;
            3'd5: return a | b;
            3'd2: return a ^ b;
            3'd6: return b * (W'(1) << (W/2));
            3'd3: return b << sh;
            default: return op[3] ? W'($signed(b) >>> sh) : (b >> sh);
        endcase
    endfunction

    function automatic logic [W-1:0] md_ref(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            2'b01:   return p[W-1:0];
            2'b10:   return (b == 0) ? '1 : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic test_reset();
        clrn = 1; drive_nop();
        step(); step();
        checks += 7;
        if (e_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0h want 0", e_busy); end
        if (ewreg !== 1'b0) begin errors++; $display("FAIL reset_ewreg: got %0h want 0", ewreg); end
        if (em2reg !== 1'b0) begin errors++; $display("FAIL reset_em2reg: got %0h want 0", em2reg); end
        if (ewmem !== 1'b0) begin errors++; $display("FAIL reset_ewmem: got %0h want 0", ewmem); end
        if (eb !== '0) begin errors++; $display("FAIL reset_eb: got %0h want 0", eb); end
        if (ern !== '0) begin errors++; $display("FAIL reset_ern: got %0h want 0", ern); end
        if (ealu !== '0) begin errors++; $display("FAIL reset_ealu: got %0h want 0", ealu); end
        clrn = 0;
    endtask

    task automatic test_alu_add();
        drive_nop();
        dwreg = 1; da = 5; db = 7; daluc = 4'b0000; drn = 5'd3;
        step();
        checks += 3;
        if (ealu !== 32'd12) begin errors++; $display("FAIL alu_add: got %0h want c", ealu); end
        if (e_busy !== 1'b0) begin errors++; $display("FAIL alu_add_busy: got %0h want 0", e_busy); end
        if (ern !== 5'd3) begin errors++; $display("FAIL alu_add_ern: got %0h want 3", ern); end
    endtask

    task automatic test_alu_random(input int n);
        logic [W-1:0] a_exp, b_exp, want;
        for (int i = 0; i < n; i++) begin
            drive_random();
            flush = 0; djal = 0; dmd = 2'b00;
            a_exp = dshift ? W'((dimm >> 6) % W) : da;
            b_exp = daluimm ? dimm : db;
            want  = alu_ref(daluc, a_exp, b_exp);
            step();
            checks += 4;
            if (ealu !== want) begin errors++; $display("FAIL alu_rand op=%0h: got %0h want %0h", daluc, ealu, want); end
            if (e_busy !== 1'b0) begin errors++; $display("FAIL alu_rand_busy: got %0h want 0", e_busy); end
            if (eb !== db) begin errors++; $display("FAIL alu_rand_eb: got %0h want %0h", eb, db); end
            if ({ewreg, em2reg, ewmem} !== {dwreg, dm2reg, dwmem}) begin
                errors++; $display("FAIL alu_rand_ctl: got %0b want %0b", {ewreg, em2reg, ewmem}, {dwreg, dm2reg, dwmem});
            end
        end
    endtask

    task automatic test_jal();
        logic [W-1:0] pcs [2];
        pcs[0] = 32'h100; pcs[1] = 32'hFFFF_FFFE;
        for (int i = 0; i < 2; i++) begin
            drive_random();
            flush = 0; djal = 1; dmd = 2'b00; dpc4 = pcs[i];
            step();
            checks += 2;
            if (ealu !== pcs[i] + LINK_OFS) begin errors++; $display("FAIL jal_link: got %0h want %0h", ealu, pcs[i] + LINK_OFS); end
            if (ern !== 5'd31) begin errors++; $display("FAIL jal_ern: got %0h want 1f", ern); end
        end
    endtask

    // Issue one MDU op (capturing edge may be the DONE->IDLE edge of a prior op),
    // scramble the D inputs and flush while busy, then check in DONE.
    task automatic run_md(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [RNW-1:0] rn;
        logic [W-1:0]   want;
        int n;
        rn = 5'($urandom);
        drive_nop();
        dwreg = 1; dwmem = 1; dmd = op; da = a; db = b; drn = rn;
        want = md_ref(op, a, b);
        step();
        n = 0;
        while (e_busy === 1'b1 && n < 100) begin
            n++;
            drive_random();
            step();
        end
        checks += 5;
        if (n !== W + 1) begin errors++; $display("FAIL md_busy_len op=%0d: got %0d want %0d", op, n, W + 1); end
        if (ealu !== want) begin errors++; $display("FAIL md_result op=%0d a=%0h b=%0h: got %0h want %0h", op, a, b, ealu, want); end
        if (eb !== b) begin errors++; $display("FAIL md_hold_eb: got %0h want %0h", eb, b); end
        if (ern !== rn) begin errors++; $display("FAIL md_hold_ern: got %0h want %0h", ern, rn); end
        if ({ewreg, em2reg, ewmem} !== 3'b101) begin errors++; $display("FAIL md_hold_ctl: got %0b want 101", {ewreg, em2reg, ewmem}); end
    endtask

    task automatic test_mdu_directed();
        run_md(2'b01, 7, 6);
        run_md(2'b01, 32'hFFFF_FFFF, 2);
        run_md(2'b10, 100, 7);
        run_md(2'b11, 100, 7);
        run_md(2'b10, 9, 0);
        run_md(2'b11, 9, 0);
    endtask

    task automatic test_back_to_back(input int n);
        logic [1:0] op;
        logic [W-1:0] b;
        for (int i = 0; i < n; i++) begin
            op = 2'(1 + $urandom_range(0, 2));
            b  = (i % 2 == 0) ? W'($urandom_range(1, 1000)) : W'($urandom);
            run_md(op, $urandom, b);
        end
    endtask

    task automatic test_flush_idle();
        drive_nop(); step();
        dwreg = 1; dm2reg = 1; dwmem = 1; dmd = 2'b01; da = $urandom; db = $urandom;
        drn = 5'd9; flush = 1;
        step();
        checks += 4;
        if ({ewreg, em2reg, ewmem} !== 3'b000) begin errors++; $display("FAIL flush_ctl: got %0b want 000", {ewreg, em2reg, ewmem}); end
        if (e_busy !== 1'b0) begin errors++; $display("FAIL flush_emd: got busy %0h want 0", e_busy); end
        if (eb !== '0) begin errors++; $display("FAIL flush_eb: got %0h want 0", eb); end
        if (ealu !== '0) begin errors++; $display("FAIL flush_ealu: got %0h want 0", ealu); end
        flush = 0; dmd = 2'b00; da = 40; db = 2; daluc = 4'b0100;
        step();
        checks += 2;
        if (ealu !== 32'd38) begin errors++; $display("FAIL after_flush_sub: got %0h want 26", ealu); end
        if ({ewreg, em2reg, ewmem} !== 3'b111) begin errors++; $display("FAIL after_flush_ctl: got %0b want 111", {ewreg, em2reg, ewmem}); end
    endtask

    task automatic test_reset_mid_op();
        drive_nop();
        dwreg = 1; dmd = 2'b01; da = 32'h1234; db = 32'h55; drn = 5'd7;
        step();
        drive_nop();
        repeat (10) step();
        checks += 1;
        if (e_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %0h want 1", e_busy); end
        clrn = 1;
        #1;
        checks += 5;
        if (e_busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %0h want 0", e_busy); end
        if (ewreg !== 1'b0) begin errors++; $display("FAIL mid_reset_ewreg: got %0h want 0", ewreg); end
        if (eb !== '0) begin errors++; $display("FAIL mid_reset_eb: got %0h want 0", eb); end
        if (ern !== '0) begin errors++; $display("FAIL mid_reset_ern: got %0h want 0", ern); end
        if (ealu !== '0) begin errors++; $display("FAIL mid_reset_ealu: got %0h want 0", ealu); end
        step();
        clrn = 0;
        run_md(2'b01, 3, 3);
    endtask

    initial begin
        drive_nop();
        clrn = 1;
        test_reset();
        test_alu_add();
        test_alu_random(40);
        test_jal();
        test_mdu_directed();
        test_back_to_back(8);
        test_flush_idle();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
